// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU definitions.
//   - FP64 field constants (bias, exponent and mantissa widths)
//   - FCVT int-to-FP state encoding
//   - RNE round-up predicate shared by the FPU rounders
package fpu_pkg;

  localparam int          FP64_EXP_W = 11;
  localparam int          FP64_MAN_W = 52;
  localparam logic [10:0] FP64_BIAS  = 11'd1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fcvt_state_e;

  // Round-to-nearest-even: round up on guard set, unless it is an exact tie
  // and the kept LSB is already even.
  function automatic logic rne_round_up(input logic guard,
                                        input logic sticky,
                                        input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fp64_rne_pack.sv
// fp64_rne_pack: combinational RNE rounding and binary64 packing of a
// normalized 64-bit magnitude.
// Ports:
//   i_sgn     - result sign
//   i_e       - unbiased exponent (0..63) of the leading one
//   i_mag     - normalized magnitude below its leading one (bits 62:0)
//   i_zero    - operand was zero; forces a +0 exact result
//   o_data    - packed binary64 result
//   o_inexact - rounding discarded nonzero bits
module fp64_rne_pack
  import fpu_pkg::*;
(
  input  logic        i_sgn,
  input  logic [6:0]  i_e,
  input  logic [62:0] i_mag,
  input  logic        i_zero,
  output logic [63:0] o_data,
  output logic        o_inexact
);

  logic [FP64_MAN_W-1:0] w_frac;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_up;
  logic [FP64_MAN_W:0]   w_frac_inc;
  logic [7:0]            w_e_adj;
  logic [FP64_EXP_W-1:0] w_exp;

  assign w_frac   = i_mag[62:11];
  assign w_guard  = i_mag[10];
  assign w_sticky = |i_mag[9:0];
  assign w_up     = rne_round_up(w_guard, w_sticky, i_mag[11]);

  // A carry out of the fraction means it was all ones: the fraction wraps
  // to zero and the exponent bumps by one (max e is then 64, no overflow).
  assign w_frac_inc = {1'b0, w_frac} + {{FP64_MAN_W{1'b0}}, w_up};
  assign w_e_adj    = {1'b0, i_e} + {7'd0, w_frac_inc[FP64_MAN_W]};
  assign w_exp      = {3'd0, w_e_adj} + FP64_BIAS;

  // Select the packed result; a zero operand yields exact +0.
  always_comb begin
    o_data    = 64'd0;
    o_inexact = 1'b0;
    if (i_zero) begin
      o_data    = 64'd0;
      o_inexact = 1'b0;
    end else begin
      o_data    = {i_sgn, w_exp, w_frac_inc[FP64_MAN_W-1:0]};
      o_inexact = w_guard | w_sticky;
    end
  end

endmodule

// File: rtl/fcvt_int_to_fp.sv
// fcvt_int_to_fp: multi-cycle int64/uint64 to binary64 converter (RNE),
// fixed 7-cycle latency from accept to result valid.
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_in_valid/o_in_ready, i_in_data, i_in_signed - operand handshake
//   o_out_valid/i_out_ready, o_out_data, o_out_inexact - result handshake
// Parameter SUPPORT_UNSIGNED=0 forces every operand to be treated as signed.
module fcvt_int_to_fp
  import fpu_pkg::*;
#(
  parameter bit SUPPORT_UNSIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_data,
  input  logic        i_in_signed,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_data,
  output logic        o_out_inexact
);

  fcvt_state_e r_state;
  logic [2:0]  r_step;
  logic [63:0] r_mag;
  logic [6:0]  r_e;
  logic        r_sgn;
  logic        r_zero;
  logic        r_out_valid;
  logic [63:0] r_out_data;
  logic        r_out_inexact;

  logic        w_is_signed;
  logic        w_sgn;
  logic [6:0]  w_shamt;
  logic [63:0] w_top_mask;
  logic [63:0] w_norm_mag;
  logic [6:0]  w_norm_e;
  logic [63:0] w_pack_data;
  logic        w_pack_inexact;

  assign w_is_signed = SUPPORT_UNSIGNED ? i_in_signed : 1'b1;
  assign w_sgn       = w_is_signed & i_in_data[63];

  // Held low through reset so nothing is accepted while the FSM is cleared.
  assign o_in_ready    = (r_state == ST_IDLE) & ~i_rst;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_out_inexact = r_out_inexact;

  // Step k shifts by 32>>k; the mask selects the top s bits of mag.
  assign w_shamt    = 7'd32 >> r_step;
  assign w_top_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> w_shamt);

  // One binary-search normalization step: shift left when the top s bits are zero.
  always_comb begin
    w_norm_mag = r_mag;
    w_norm_e   = r_e;
    if ((r_mag & w_top_mask) == 64'd0) begin
      w_norm_mag = r_mag << w_shamt;
      w_norm_e   = r_e - w_shamt;
    end else begin
      w_norm_mag = r_mag;
      w_norm_e   = r_e;
    end
  end

  fp64_rne_pack u_pack (
    .i_sgn     (r_sgn),
    .i_e       (r_e),
    .i_mag     (r_mag[62:0]),
    .i_zero    (r_zero),
    .o_data    (w_pack_data),
    .o_inexact (w_pack_inexact)
  );

  // Conversion FSM: accept, six normalization steps, round/pack, hold result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_step        <= 3'd0;
      r_mag         <= 64'd0;
      r_e           <= 7'd0;
      r_sgn         <= 1'b0;
      r_zero        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= 64'd0;
      r_out_inexact <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_sgn   <= w_sgn;
            // Negating the most negative value wraps back to 2^63, which is
            // exactly its magnitude when read as unsigned.
            r_mag   <= w_sgn ? (64'd0 - i_in_data) : i_in_data;
            r_e     <= 7'd63;
            r_zero  <= (i_in_data == 64'd0);
            r_step  <= 3'd0;
            r_state <= ST_NORM;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_NORM: begin
          r_mag <= w_norm_mag;
          r_e   <= w_norm_e;
          if (r_step == 3'd5) begin
            r_step  <= 3'd0;
            r_state <= ST_ROUND;
          end else begin
            r_step  <= r_step + 3'd1;
          end
        end
        ST_ROUND: begin
          r_out_data    <= w_pack_data;
          r_out_inexact <= w_pack_inexact;
          r_out_valid   <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
